// File: rtl/uart_reg_ctrl_if.sv
// uart_reg_ctrl_if: single-beat CPU register bus between the peripheral bridge
// and the UART register front-end; ack/rdata return one cycle after req.
interface uart_reg_ctrl_if;
    logic        req;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: UART register front-end, TX/RX byte buffering and link scheduler.
// Optional UART_REG_CTRL_RX_FIFO_EN turns the RX holding register into a 4-deep FIFO.
module uart_reg_ctrl #(
    parameter int               DIV_W     = 16,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd868
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_reg_ctrl_if.slave   bus,
    output logic [DIV_W-1:0] divider,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    input  logic             tx_busy,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_busy,
    output logic             rx_en,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OFFER,
        S_WAIT_RX
    } state_e;

    localparam logic [1:0] M_SIMPLEX = 2'b00;
    localparam logic [1:0] M_HALF    = 2'b01;
    localparam logic [1:0] M_FULL    = 2'b10;

    localparam logic [5:0] A_DIV  = 6'd0;
    localparam logic [5:0] A_RXD  = 6'd1;
    localparam logic [5:0] A_RXS  = 6'd2;
    localparam logic [5:0] A_TXD  = 6'd3;
    localparam logic [5:0] A_TXS  = 6'd4;
    localparam logic [5:0] A_MASK = 6'd5;
    localparam logic [5:0] A_STAT = 6'd6;
    localparam logic [5:0] A_VER  = 6'd7;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       mask_q, mask_d;
    logic             tx_full_q, tx_full_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             ovr_q, ovr_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;

    logic       rd, wr;
    logic [5:0] sel;
    logic       rx_avail, rx_full, rx_src_d;
    logic       pop, push, ovr_set;
    logic [7:0] rx_head;
    logic [3:0] rxs_ext;
    logic       unused_bits;

    assign rd  = bus.req & ~bus.we;
    assign wr  = bus.req & bus.we;
    assign sel = bus.addr[7:2];
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // A pop frees the slot in the same cycle, so a coincident byte is kept.
    assign pop     = rd & (sel == A_RXD) & rx_avail;
    assign push    = rx_valid & (~rx_full | pop);
    assign ovr_set = rx_valid & rx_full & ~pop;

`ifdef UART_REG_CTRL_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [1:0] wp_q, wp_d, rp_q, rp_d;
    logic [2:0] cnt_q, cnt_d;

    assign rx_avail = (cnt_q != 3'd0);
    assign rx_full  = (cnt_q == 3'd4);
    assign rx_head  = fifo_q[rp_q];
    assign rxs_ext  = {rx_avail, cnt_q};
    assign rx_src_d = (cnt_d != 3'd0);

    always_comb begin
        fifo_d = fifo_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (push) begin
            fifo_d[wp_q] = rx_data;
            wp_d         = wp_q + 2'd1;
        end
        if (pop) begin
            rp_d = rp_q + 2'd1;
        end
        cnt_d = cnt_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            fifo_q <= fifo_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    assign rx_avail = rx_full_q;
    assign rx_full  = rx_full_q;
    assign rx_head  = rx_byte_q;
    assign rxs_ext  = 4'b0;
    assign rx_src_d = rx_full_d;

    always_comb begin
        rx_full_d = push | (rx_full_q & ~pop);
        rx_byte_d = push ? rx_data : rx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
        end else begin
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
        end
    end
`endif

    // Once OFFER is entered only a handshake may leave it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tx_full_q) begin
                    if (mode_q == M_HALF && rx_busy) state_d = S_WAIT_RX;
                    else                             state_d = S_OFFER;
                end
            end
            S_WAIT_RX: begin
                if (!rx_busy) state_d = S_OFFER;
            end
            S_OFFER: begin
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        mask_d    = mask_q;
        tx_full_d = tx_full_q;
        tx_byte_d = tx_byte_q;
        ovr_d     = ovr_q;
        ack_d     = bus.req;
        rdata_d   = '0;

        if (tx_valid && tx_ready) tx_full_d = 1'b0;

        if (wr) begin
            case (sel)
                A_DIV:  div_d = bus.wdata[DIV_W-1:0];
                A_RXS:  if (bus.wdata[1]) ovr_d = 1'b0;
                A_TXD: begin
                    if (!tx_full_q) begin
                        tx_full_d = 1'b1;
                        tx_byte_d = bus.wdata[7:0];
                    end
                end
                A_MASK: mask_d = bus.wdata[2:0];
                A_STAT: mode_d = (bus.wdata[1:0] == 2'b11) ? M_FULL
                                                           : bus.wdata[1:0];
                default: ;
            endcase
        end

        if (ovr_set) ovr_d = 1'b1;

        if (rd) begin
            case (sel)
                A_DIV:  rdata_d = 32'(div_q);
                A_RXD:  rdata_d = rx_avail ? {24'b0, rx_head} : 32'b0;
                A_RXS:  rdata_d = {26'b0, rxs_ext, ovr_q, rx_full};
                A_TXS:  rdata_d = {30'b0, tx_busy, tx_full_q};
                A_MASK: rdata_d = {29'b0, mask_q};
                A_STAT: rdata_d = {28'b0, tx_busy, rx_busy, mode_q};
                A_VER:  rdata_d = 32'h0001_0000;
                default: rdata_d = '0;
            endcase
        end

        irq_d = |(mask_d & {ovr_d, ~tx_full_d, rx_src_d});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= DIV_RESET;
            mode_q    <= M_FULL;
            mask_q    <= '0;
            tx_full_q <= 1'b0;
            tx_byte_q <= '0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            tx_full_q <= tx_full_d;
            tx_byte_q <= tx_byte_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign divider   = div_q;
    assign tx_valid  = (state_q == S_OFFER);
    assign tx_data   = tx_byte_q;
    assign irq       = irq_q;
    assign rx_en     = (mode_q != M_SIMPLEX) & ~((mode_q == M_HALF) & tx_busy);

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb_uart_reg_ctrl: directed plus random stimulus against a queue-based
// reference model; bus responses are checked through a tagged scoreboard.
module tb_uart_reg_ctrl;

`ifdef UART_REG_CTRL_RX_FIFO_EN
    localparam int RXD = 4;
`else
    localparam int RXD = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divider;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_busy = 1'b0;
    logic        rx_en;
    logic        irq;

    uart_reg_ctrl_if bus_if ();

    uart_reg_ctrl #(.DIV_W(16), .DIV_RESET(16'd868)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .divider  (divider),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_busy  (rx_busy),
        .rx_en    (rx_en),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    // Reference model state: what a programmer sees through the register map.
    logic [15:0] m_div;
    logic [1:0]  m_mode;
    logic [2:0]  m_mask;
    bit          m_txf;
    logic [7:0]  m_txb;
    bit          m_offer;
    bit          m_wait;
    bit          m_ovr;
    logic [7:0]  rxq[$];

    task automatic m_reset();
        m_div   = 16'd868;
        m_mode  = 2'b10;
        m_mask  = 3'b0;
        m_txf   = 0;
        m_txb   = 8'h0;
        m_offer = 0;
        m_wait  = 0;
        m_ovr   = 0;
        rxq.delete();
    endtask

    function automatic logic [31:0] m_read(int idx);
        logic [3:0] ext;
        int n;
        n = rxq.size();
`ifdef UART_REG_CTRL_RX_FIFO_EN
        ext = {n != 0, 3'(n)};
`else
        ext = 4'b0;
`endif
        case (idx)
            0: return 32'(m_div);
            1: return (n > 0) ? 32'(rxq[0]) : 32'h0;
            2: return {26'b0, ext, m_ovr, n == RXD};
            4: return {30'b0, tx_busy, m_txf};
            5: return 32'(m_mask);
            6: return {28'b0, tx_busy, rx_busy, m_mode};
            7: return 32'h0001_0000;
            default: return 32'h0;
        endcase
    endfunction

    // Model: compare the present outputs, then advance across the next edge.
    always @(negedge clk) begin
        bit   mapped, old_txf;
        int   idx;
        logic exp_irq;
        exp_t e;
        if (!rst_n) m_reset();
        exp_irq = (m_mask[2] & m_ovr) | (m_mask[1] & !m_txf) |
                  (m_mask[0] & (rxq.size() != 0));
        chk("tx_valid", 32'(tx_valid), 32'(m_offer));
        chk("tx_data", 32'(tx_data), 32'(m_txb));
        chk("irq", 32'(irq), 32'(exp_irq));
        chk("divider", 32'(divider), 32'(m_div));
        chk("rx_en", 32'(rx_en),
            32'((m_mode != 2'b00) && !(m_mode == 2'b01 && tx_busy)));
        if (rst_n) begin
            mapped  = (bus_if.addr[7:5] == 3'b0);
            idx     = int'(bus_if.addr) / 4;
            old_txf = m_txf;
            if (bus_if.req) begin
                e.cyc  = cyc;
                e.rd   = !bus_if.we;
                e.addr = bus_if.addr;
                e.data = (!bus_if.we && mapped) ? m_read(idx) : 32'h0;
                sb.push_back(e);
            end
            if (m_offer) begin
                if (tx_ready) begin
                    m_offer = 0;
                    m_txf   = 0;
                end
            end else if (m_wait) begin
                if (!rx_busy) begin
                    m_wait  = 0;
                    m_offer = 1;
                end
            end else if (m_txf) begin
                if (m_mode == 2'b01 && rx_busy) m_wait = 1;
                else                            m_offer = 1;
            end
            if (bus_if.req && bus_if.we && mapped) begin
                case (idx)
                    0: m_div = bus_if.wdata[15:0];
                    2: if (bus_if.wdata[1]) m_ovr = 0;
                    3: if (!old_txf) begin
                        m_txf = 1;
                        m_txb = bus_if.wdata[7:0];
                    end
                    5: m_mask = bus_if.wdata[2:0];
                    6: m_mode = (bus_if.wdata[1:0] == 2'b11) ? 2'b10
                                                             : bus_if.wdata[1:0];
                    default: ;
                endcase
            end
            if (bus_if.req && !bus_if.we && mapped && idx == 1 && rxq.size() > 0)
                void'(rxq.pop_front());
            if (rx_valid) begin
                if (rxq.size() < RXD) rxq.push_back(rx_data);
                else                  m_ovr = 1;
            end
        end
    end

    // Monitor: an access issued before edge N must be acked right after it.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e = sb.pop_front();
            chk("ack", 32'(bus_if.ack), 32'h1);
            if (e.rd) chk($sformatf("rdata@%02h", e.addr), bus_if.rdata, e.data);
        end else begin
            chk("ack_idle", 32'(bus_if.ack), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] d);
        bus_if.req   = 1'b1;
        bus_if.we    = w;
        bus_if.addr  = a;
        bus_if.wdata = d;
        step();
        bus_if.req   = 1'b0;
    endtask

    initial begin
        int a;
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 8'h0;
        bus_if.wdata = 32'h0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        acc(0, 8'h1C, 0);
        acc(0, 8'h00, 0);
        acc(0, 8'h18, 0);
        idle(1);

        acc(1, 8'h0C, 32'hA5);
        idle(5);
        acc(1, 8'h0C, 32'h3C);
        acc(0, 8'h10, 0);
        idle(1);
        tx_ready = 1'b1;
        idle(2);
        tx_ready = 1'b0;
        idle(2);

        acc(1, 8'h18, 32'h1);
        rx_busy = 1'b1;
        acc(1, 8'h0C, 32'h55);
        idle(4);
        rx_busy = 1'b0;
        idle(2);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        tx_busy  = 1'b1;
        idle(2);
        tx_busy  = 1'b0;
        acc(1, 8'h18, 32'h2);

        rx_valid = 1'b1;
        rx_data  = 8'h11;
        step();
        rx_data  = 8'h22;
        step();
        rx_valid = 1'b0;
        acc(0, 8'h04, 0);
        acc(0, 8'h08, 0);
        acc(1, 8'h08, 32'h2);
        acc(0, 8'h08, 0);
        repeat (4) acc(0, 8'h04, 0);

        rx_valid = 1'b1;
        rx_data  = 8'h11;
        step();
        rx_data  = 8'h77;
        acc(0, 8'h04, 0);
        rx_valid = 1'b0;
        acc(0, 8'h04, 0);
        acc(0, 8'h08, 0);
        acc(0, 8'h04, 0);

        acc(1, 8'h14, 32'h2);
        idle(1);
        acc(1, 8'h0C, 32'h9A);
        idle(3);
        chk("pre_rst_txv", 32'(tx_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_txv", 32'(tx_valid), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        acc(0, 8'h10, 0);

        for (int i = 0; i < 3000; i++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
            tx_busy  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rx_busy = !rx_busy;
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom_range(0, 9));
                bus_if.req   = 1'b1;
                bus_if.we    = 1'($urandom_range(0, 1));
                bus_if.addr  = (a < 8) ? 8'(a * 4 + int'($urandom_range(0, 3)))
                                       : 8'($urandom_range(32, 255));
                bus_if.wdata = $urandom;
            end else begin
                bus_if.req = 1'b0;
            end
            step();
        end
        bus_if.req = 1'b0;
        rx_valid   = 1'b0;
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
- Memory-mapped register front-end and link scheduler for the UART TX/RX engines.
- Decodes CPU-side single-beat register accesses, holds the baud divider and IRQ mask, and buffers one TX byte and one RX byte.
- Gates the TX engine according to the communication mode (simplex / half-duplex / full-duplex).
- Sits between the peripheral bus bridge and the uart_tx / uart_rx engines.

Parameters:
- DIV_W, 16, width of baud divider register.
- DIV_RESET, 16'd868, divider value after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  bus access request, one cycle per access
- we  in  1  1=write, 0=read; valid with req
- addr  in  8  byte address; bits [1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, valid with ack
- ack  out  1  access complete, exactly 1 cycle after req
- divider  out  DIV_W  baud divider to both engines
- tx_valid  out  1  byte available to TX engine
- tx_data  out  8  byte to transmit
- tx_ready  in  1  TX engine accepts byte when tx_valid&tx_ready
- tx_busy  in  1  TX engine shifting
- rx_valid  in  1  one-cycle pulse, received byte on rx_data
- rx_data  in  8  received byte
- rx_busy  in  1  RX engine mid-frame
- rx_en  out  1  RX engine enable
- irq  out  1  level interrupt

Behaviour:
- Register map (word offsets):
  - 0x00 DIVIDER rw
  - 0x04 RXDATA ro: [7:0] byte; a read pops the byte
  - 0x08 RXSTATUS: [0] rx_full ro, [1] overrun, write 1 to clear
  - 0x0C TXDATA wo: [7:0]
  - 0x10 TXSTATUS ro: [0] tx_full, [1] tx_busy
  - 0x14 IRQMASK rw: [0] rx_full, [1] tx_empty, [2] overrun
  - 0x18 UART_STATUS: [1:0] mode rw (00 SIMPLEX, 01 HALFDUPLEX, 10 FULLDUPLEX; 11 is written as 10), [2] rx_busy ro, [3] tx_busy ro
  - 0x1C VERSION ro = {16'h1, 8'h0, 8'h0}
- Unmapped reads return 0; unmapped writes are ignored, still acked.
- Reset values: divider=DIV_RESET; mode=FULLDUPLEX; mask=0; rdata=0; ack=0; tx_valid=0; tx_data=0; rx holding register empty, overrun=0; irq=0.
- Access timing: registered. ack and rdata are asserted in the cycle after req. A write takes effect at the same edge that raises ack. A req asserted while ack is high is accepted (back-to-back accesses allowed).
- TX path: 1-entry holding register. Writing TXDATA with tx_full=0 loads the byte and sets tx_full. Writing TXDATA with tx_full=1 drops the write and leaves the register unchanged. tx_full clears on tx_valid&tx_ready.
- Link scheduler FSM, states IDLE, OFFER, WAIT_RX:
  - IDLE -> OFFER when tx_full and (mode!=HALFDUPLEX or !rx_busy).
  - IDLE -> WAIT_RX when tx_full, mode=HALFDUPLEX and rx_busy.
  - WAIT_RX -> OFFER when rx_busy falls.
  - OFFER drives tx_valid=1 with tx_data stable until tx_ready; then -> IDLE.
  - tx_valid never deasserts without a handshake, even if the mode changes while in OFFER.
- rx_en = (mode!=SIMPLEX) & !(mode==HALFDUPLEX & tx_busy).
- RX path: an rx_valid pulse with rx_full=0 stores the byte and sets rx_full. An rx_valid pulse with rx_full=1 keeps the old byte and sets overrun.
  - Same-cycle RXDATA read and rx_valid: the pop wins first, the new byte is stored, rx_full stays 1, overrun is not set.
  - Reading RXDATA when empty returns 0 and changes no state.
- irq registered: irq = |(mask & {overrun, !tx_full, rx_full}).
- Reset mid-operation: all state returns to reset values asynchronously. Any pending TX or RX byte is discarded.

Optional Feature:
- Macro UART_REG_CTRL_RX_FIFO_EN.
- When defined: the RX holding register becomes a 4-entry FIFO. RXSTATUS[4:2] reports the fill count (0..4). rx_full means count=4; bit [5] rx_nonempty drives the rx_full IRQ source. Overrun is set when the FIFO is full at rx_valid. FIFO pointers wrap modulo 4.
- When undefined: single holding register as above. RXSTATUS[5:2] read 0.

Test Plan:
- Reset: release rst_n, read 0x1C -> ack next cycle, rdata=32'h00010000; read 0x00 -> 868; read 0x18 -> 2'b10.
- TX full-duplex: write 0x0C=8'hA5, hold tx_ready=0 for 5 cycles -> tx_valid high, tx_data=A5 stable; second write 8'h3C dropped; tx_ready=1 -> tx_full clears; no 3C ever sent.
- Half-duplex gating: mode=01, rx_busy=1, write TXDATA=8'h55 -> tx_valid stays 0; drop rx_busy -> tx_valid next cycle; with tx_busy=1 -> rx_en=0.
- RX overrun: pulse rx_valid 8'h11 then 8'h22 -> RXDATA reads 11, RXSTATUS[1]=1; write 0x08=2 -> overrun 0.
- Simultaneous pop and receive: rx_full=1 with byte 11, read RXDATA in the same cycle as rx_valid 8'h77 -> rdata=11, next read returns 77, overrun=0.
- IRQ: mask=3'b010 with TX empty -> irq=1; write TXDATA -> irq=0 until the handshake completes; assert rst_n=0 mid-OFFER -> tx_valid=0 and irq=0 immediately.
